rom_access: RTL and testbench

ROM_ACCESS -- requirements
Module: rom_access

---
 rtl/rom_access.sv | 183 ++++++++++++++++++
 tb/tb_rom_access.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access.sv
// Single-port async SRAM/ROM arbiter: the SNES master has priority over the MCU master.
// SNES requests are stored in a one-deep pending slot, and the external strobes are registered.
module rom_access #(
  parameter int READ_CYCLES  = 6,
  parameter int WRITE_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snes_req,
  input  logic        snes_we,
  input  logic        snes_hit,
  input  logic        snes_writable,
  input  logic [23:0] snes_addr,
  input  logic [7:0]  snes_din,
  output logic [7:0]  snes_dout,
  output logic        snes_dvalid,
  output logic        snes_ovr,
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_din,
  output logic [7:0]  mcu_dout,
  output logic        mcu_rdy,
  output logic [22:0] mem_a,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_ble_n,
  output logic        mem_bhe_n,
  output logic [15:0] mem_dq_out,
  output logic        mem_dq_oe,
  input  logic [15:0] mem_dq_in
);

  typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR, RECOVER} state_t;

  localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        lane_hi;
  logic        pend_valid;
  logic        pend_we;
  logic        pend_ok;
  logic [23:0] pend_addr;
  logic [7:0]  pend_din;

  logic        new_snes;
  logic        sel_we;
  logic        sel_ok;
  logic [23:0] sel_addr;
  logic [7:0]  sel_din;
  logic        start_snes;
  logic        start_mcu;
  logic        drop;
  logic        acc_we;
  logic [23:0] acc_addr;
  logic [7:0]  acc_din;
  logic [7:0]  rd_byte;

  // In IDLE, a request arriving this cycle is served directly; it is the newest request and therefore wins over the slot.
  assign new_snes   = snes_req & snes_hit;
  assign sel_we     = new_snes ? snes_we       : pend_we;
  assign sel_ok     = new_snes ? snes_writable : pend_ok;
  assign sel_addr   = new_snes ? snes_addr     : pend_addr;
  assign sel_din    = new_snes ? snes_din      : pend_din;
  assign start_snes = (state == IDLE) && (new_snes || pend_valid);
  assign drop       = start_snes && sel_we && !sel_ok;
  assign start_mcu  = (state == IDLE) && !start_snes && mcu_req;
  assign acc_we     = start_snes ? sel_we   : mcu_we;
  assign acc_addr   = start_snes ? sel_addr : mcu_addr;
  assign acc_din    = start_snes ? sel_din  : mcu_din;
  assign rd_byte    = lane_hi ? mem_dq_in[15:8] : mem_dq_in[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lane_hi     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_we     <= 1'b0;
      pend_ok     <= 1'b0;
      pend_addr   <= '0;
      pend_din    <= '0;
      snes_dout   <= '0;
      snes_dvalid <= 1'b0;
      snes_ovr    <= 1'b0;
      mcu_dout    <= '0;
      mcu_rdy     <= 1'b0;
      mem_a       <= '0;
      mem_ce_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_ble_n   <= 1'b1;
      mem_bhe_n   <= 1'b1;
      mem_dq_out  <= '0;
      mem_dq_oe   <= 1'b0;
    end else begin
      snes_dvalid <= 1'b0;
      mcu_rdy     <= 1'b0;

      if (new_snes) begin
        pend_valid <= 1'b1;
        pend_we    <= snes_we;
        pend_ok    <= snes_writable;
        pend_addr  <= snes_addr;
        pend_din   <= snes_din;
        if (pend_valid)
          snes_ovr <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_snes)
            pend_valid <= 1'b0;
          if (drop) begin
            snes_dvalid <= 1'b1;
          end else if (start_snes || start_mcu) begin
            mem_a     <= acc_addr[23:1];
            lane_hi   <= acc_addr[0];
            mem_ce_n  <= 1'b0;
            mem_ble_n <= acc_addr[0];
            mem_bhe_n <= ~acc_addr[0];
            cnt       <= '0;
            if (acc_we) begin
              mem_dq_oe  <= 1'b1;
              mem_dq_out <= {acc_din, acc_din};
              state      <= start_snes ? SWR : MWR;
            end else begin
              mem_oe_n <= 1'b0;
              state    <= start_snes ? SRD : MRD;
            end
          end
        end

        SRD, MRD: begin
          if (cnt == RD_LAST) begin
            if (state == SRD) begin
              snes_dout   <= rd_byte;
              snes_dvalid <= 1'b1;
            end else begin
              mcu_dout <= rd_byte;
              mcu_rdy  <= 1'b1;
            end
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_ble_n <= 1'b1;
            mem_bhe_n <= 1'b1;
            state     <= RECOVER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        // WE_N is asserted one cycle after CE_N so that address and data have a setup cycle.
        SWR, MWR: begin
          if (cnt == 4'd0)
            mem_we_n <= 1'b0;
          if (cnt == WR_LAST) begin
            if (state == SWR)
              snes_dvalid <= 1'b1;
            else
              mcu_rdy <= 1'b1;
            mem_ce_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_ble_n <= 1'b1;
            mem_bhe_n <= 1'b1;
            mem_dq_oe <= 1'b0;
            state     <= RECOVER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        RECOVER: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_access.sv
// Directed bench for rom_access: completions are scoreboarded against expected DOUT values
// pushed when each request is driven, and strobe activity is counted by a negedge monitor.
module tb_rom_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snes_req, snes_we, snes_hit, snes_writable;
  logic [23:0] snes_addr;
  logic [7:0]  snes_din;
  logic [7:0]  snes_dout;
  logic        snes_dvalid, snes_ovr;
  logic        mcu_req, mcu_we;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_din;
  logic [7:0]  mcu_dout;
  logic        mcu_rdy;
  logic [22:0] mem_a;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_ble_n, mem_bhe_n;
  logic [15:0] mem_dq_out;
  logic        mem_dq_oe;
  logic [15:0] mem_dq_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int snes_done_n = 0;
  int mcu_done_n = 0;
  int snes_done_cyc = 0;
  int mcu_done_cyc = 0;
  int ce_low = 0;
  int oe_low = 0;
  int we_low = 0;
  int start_cyc;
  logic [7:0] snes_q[$];
  logic [7:0] mcu_q[$];

  rom_access #(.READ_CYCLES(6), .WRITE_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .snes_req(snes_req), .snes_we(snes_we), .snes_hit(snes_hit),
    .snes_writable(snes_writable), .snes_addr(snes_addr), .snes_din(snes_din),
    .snes_dout(snes_dout), .snes_dvalid(snes_dvalid), .snes_ovr(snes_ovr),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
    .mcu_dout(mcu_dout), .mcu_rdy(mcu_rdy),
    .mem_a(mem_a), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_ble_n(mem_ble_n), .mem_bhe_n(mem_bhe_n),
    .mem_dq_out(mem_dq_out), .mem_dq_oe(mem_dq_oe), .mem_dq_in(mem_dq_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_snes(input logic we, input logic ok, input logic [23:0] addr, input logic [7:0] din);
    snes_req = 1'b1; snes_hit = 1'b1; snes_we = we; snes_writable = ok;
    snes_addr = addr; snes_din = din;
  endtask

  task automatic clear_counts();
    ce_low = 0; oe_low = 0; we_low = 0;
  endtask

  task automatic wait_snes(input int target, input string tag);
    int k = 0;
    while (snes_done_n < target && k < 40) begin
      tick();
      k++;
    end
    check_output(tag, 32'(snes_done_n >= target), 32'd1);
  endtask

  task automatic wait_mcu(input int target, input string tag);
    int k = 0;
    while (mcu_done_n < target && k < 40) begin
      tick();
      k++;
    end
    mcu_req = 1'b0;
    check_output(tag, 32'(mcu_done_n >= target), 32'd1);
  endtask

  // Scoreboard, strobe counters and the DQ_OE exclusivity invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_ce_n) ce_low++;
      if (!mem_oe_n) oe_low++;
      if (!mem_we_n) we_low++;
      check_output("dq_oe_only_in_write", 32'(mem_dq_oe & (mem_ce_n | ~mem_oe_n)), 32'd0);
      if (snes_dvalid) begin
        snes_done_n++;
        snes_done_cyc = cyc;
        if (snes_q.size() == 0) check_output("snes_unexpected_dvalid", 32'd1, 32'd0);
        else check_output("snes_dout", 32'(snes_dout), 32'(snes_q.pop_front()));
      end
      if (mcu_rdy) begin
        mcu_done_n++;
        mcu_done_cyc = cyc;
        if (mcu_q.size() == 0) check_output("mcu_unexpected_rdy", 32'd1, 32'd0);
        else check_output("mcu_dout", 32'(mcu_dout), 32'(mcu_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    snes_req = 0; snes_we = 0; snes_hit = 0; snes_writable = 0; snes_addr = '0; snes_din = '0;
    mcu_req = 0; mcu_we = 0; mcu_addr = '0; mcu_din = '0; mem_dq_in = '0;
    repeat (3) tick();
    check_output("rst_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ble_n, mem_bhe_n}), 32'h1f);
    check_output("rst_dq_oe", 32'(mem_dq_oe), 32'd0);
    check_output("rst_mem_a", 32'(mem_a), 32'd0);
    check_output("rst_douts", 32'({snes_dout, mcu_dout}), 32'd0);
    check_output("rst_pulses", 32'({snes_dvalid, mcu_rdy, snes_ovr}), 32'd0);
    rst_n = 1'b1;
    tick();

    // SNES read from an odd address uses the high lane.
    mem_dq_in = 16'hA55A;
    clear_counts();
    start_cyc = cyc;
    apply_snes(1'b0, 1'b0, 24'h000101, 8'h00);
    snes_q.push_back(8'hA5);
    tick();
    snes_req = 1'b0;
    check_output("srd_mem_a", 32'(mem_a), 32'h000080);
    check_output("srd_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ble_n, mem_bhe_n}), 32'b00110);
    wait_snes(1, "srd_timeout");
    check_output("srd_latency", 32'(snes_done_cyc - start_cyc), 32'd7);
    check_output("srd_ce_cycles", 32'(ce_low), 32'd6);
    check_output("srd_oe_cycles", 32'(oe_low), 32'd6);

    // Writable SNES write: low lane, duplicated data, one-cycle WE_N setup.
    clear_counts();
    start_cyc = cyc;
    apply_snes(1'b1, 1'b1, 24'hE00000, 8'h3C);
    snes_q.push_back(8'hA5);
    tick();
    snes_req = 1'b0;
    check_output("swr_mem_a", 32'(mem_a), 32'h700000);
    check_output("swr_strobes_setup", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ble_n, mem_bhe_n}), 32'b01101);
    check_output("swr_dq", 32'({mem_dq_oe, mem_dq_out}), 32'h13C3C);
    tick();
    check_output("swr_we_low", 32'(mem_we_n), 32'd0);
    wait_snes(2, "swr_timeout");
    check_output("swr_latency", 32'(snes_done_cyc - start_cyc), 32'd6);
    check_output("swr_ce_cycles", 32'(ce_low), 32'd5);
    check_output("swr_we_cycles", 32'(we_low), 32'd4);

    // Non-writable SNES write is dropped with no strobes.
    clear_counts();
    start_cyc = cyc;
    apply_snes(1'b1, 1'b0, 24'hE00000, 8'h3C);
    snes_q.push_back(8'hA5);
    tick();
    snes_req = 1'b0;
    wait_snes(3, "drop_timeout");
    check_output("drop_latency", 32'(snes_done_cyc - start_cyc), 32'd1);
    repeat (2) tick();
    check_output("drop_ce_cycles", 32'(ce_low), 32'd0);

    // Simultaneous SNES and MCU requests: SNES first, then MCU after RECOVER.
    mem_dq_in = 16'h1234;
    start_cyc = cyc;
    apply_snes(1'b0, 1'b0, 24'h000010, 8'h00);
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h000021;
    snes_q.push_back(8'h34);
    mcu_q.push_back(8'h12);
    tick();
    snes_req = 1'b0;
    check_output("arb_mem_a", 32'(mem_a), 32'h000008);
    wait_mcu(1, "arb_mcu_timeout");
    check_output("arb_snes_latency", 32'(snes_done_cyc - start_cyc), 32'd7);
    check_output("arb_mcu_latency", 32'(mcu_done_cyc - start_cyc), 32'd15);
    check_output("ovr_still_clear", 32'(snes_ovr), 32'd0);

    // Two SNES requests during an MCU write: only the second one is serviced.
    mem_dq_in = 16'hBEEF;
    n = snes_done_n;
    start_cyc = cyc;
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 24'h000003; mcu_din = 8'h77;
    mcu_q.push_back(8'h12);
    tick();
    check_output("mwr_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ble_n, mem_bhe_n}), 32'b01110);
    check_output("mwr_dq_out", 32'(mem_dq_out), 32'h7777);
    apply_snes(1'b0, 1'b0, 24'h000004, 8'h00);
    tick();
    apply_snes(1'b0, 1'b0, 24'h000007, 8'h00);
    snes_q.push_back(8'hBE);
    tick();
    snes_req = 1'b0;
    check_output("ovr_set", 32'(snes_ovr), 32'd1);
    wait_mcu(2, "ovr_mcu_timeout");
    wait_snes(n + 1, "ovr_snes_timeout");
    check_output("ovr_worst_latency", 32'(snes_done_cyc - start_cyc), 32'd14);
    repeat (10) tick();
    check_output("ovr_single_service", 32'(snes_done_n), 32'(n + 1));
    check_output("ovr_sticky", 32'(snes_ovr), 32'd1);

    // Reset in the middle of an SNES read aborts it without a completion pulse.
    n = snes_done_n;
    mem_dq_in = 16'h00C3;
    apply_snes(1'b0, 1'b0, 24'h000000, 8'h00);
    tick();
    snes_req = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ble_n, mem_bhe_n}), 32'h1f);
    check_output("abort_outs", 32'({mem_dq_oe, snes_dvalid, snes_ovr, snes_dout}), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (8) tick();
    check_output("abort_no_dvalid", 32'(snes_done_n), 32'(n));
    check_output("abort_no_restart", 32'(ce_low), 32'd0);

    // After release, a fresh request runs with normal latency.
    start_cyc = cyc;
    apply_snes(1'b0, 1'b0, 24'h000000, 8'h00);
    snes_q.push_back(8'hC3);
    tick();
    snes_req = 1'b0;
    wait_snes(n + 1, "post_rst_timeout");
    check_output("post_rst_latency", 32'(snes_done_cyc - start_cyc), 32'd7);
    check_output("scoreboard_drained", 32'(snes_q.size() + mcu_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
